// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU controller driving an external one-bit arithmetic extender
// Optional signed-overflow flag on v: define ALU_SERIAL_CTRL_OVF_FLAG_EN.
module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ext_M,
   output logic             ext_S1,
   output logic             ext_S0,
   output logic             ext_b,
   input  logic             ext_y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             v
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_zero;

   logic             w_accept;
   logic             w_shift;
   logic             w_last;
   logic             w_x;
   logic             w_sum;
   logic             w_carry_nxt;
   logic [WIDTH-1:0] w_result_nxt;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_shift  = (r_state == S_SHIFT);
   assign w_last   = w_shift && (r_cnt == LAST);

   // Operands shift right each SHIFT cycle so bit 0 is always the current bit.
   always_comb begin
      w_x = 1'b0;
      if (r_op[2]) begin
         w_x = r_a[0];
      end else begin
         case (r_op[1:0])
            2'b00:   w_x = r_a[0] & r_b[0];
            2'b01:   w_x = r_a[0] | r_b[0];
            2'b10:   w_x = r_a[0] ^ r_b[0];
            default: w_x = ~r_a[0];
         endcase
      end
   end

   assign w_sum        = w_x ^ ext_y ^ r_carry;
   assign w_carry_nxt  = (w_x & ext_y) | (w_x & r_carry) | (ext_y & r_carry);
   assign w_result_nxt = {w_sum, r_result[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_cnt == LAST) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ext_M  = 1'b0;
      ext_S1 = 1'b0;
      ext_S0 = 1'b0;
      ext_b  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_SHIFT: begin
            ext_M  = r_op[2];
            ext_S1 = r_op[1];
            ext_S0 = r_op[0];
            ext_b  = r_b[0];
            busy   = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Subtract and increment need the +1 injected as the initial carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_a      <= a;
         r_b      <= b;
         r_op     <= op;
         r_carry  <= (op == 3'b101) || (op == 3'b110);
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_shift) begin
         r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_carry  <= w_carry_nxt;
         r_result <= w_result_nxt;
         if (w_last) begin
            r_cout <= w_carry_nxt;
            r_zero <= (w_result_nxt == '0);
         end
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign zero   = r_zero;

`ifdef ALU_SERIAL_CTRL_OVF_FLAG_EN
   logic r_v;

   // On the MSB cycle r_carry is the carry into the MSB, w_carry_nxt the carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= 1'b0;
      end else if (w_accept) begin
         r_v <= 1'b0;
      end else if (w_last) begin
         r_v <= r_op[2] & (r_carry ^ w_carry_nxt);
      end
   end

   assign v = r_v;
`else
   assign v = 1'b0;
`endif

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  3  operation select {M,S1,S0}.
REQ-006 SHALL have ports a, b  input  WIDTH  operands A and B.
REQ-007 SHALL have ports ext_M, ext_S1, ext_S0, ext_b  output  1  drive the arithmetic extender M, S1, S0, b_i.
REQ-008 SHALL have port ext_y  input  1  extender y_i, combinational response to ext_* in the same cycle.
REQ-009 SHALL have ports busy, done  output  1  operation in progress, one-cycle completion pulse.
REQ-010 SHALL have ports result  output  WIDTH, and cout, zero, v  output  1  result and flags.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start, SHIFT->DONE after WIDTH SHIFT cycles, DONE->IDLE unconditionally.
REQ-012 SHALL capture a, b, op into internal registers on the clk edge where state=IDLE and start=1; start in SHIFT or DONE SHALL be ignored, not queued.
REQ-013 SHALL process one bit per SHIFT cycle, LSB first, using a bit counter 0..WIDTH-1.
REQ-014 SHALL drive ext_M/ext_S1/ext_S0 from captured op and ext_b from the current B bit during SHIFT, and all four low in IDLE and DONE.
REQ-015 SHALL form x_i: M=1 -> A bit; M=0 -> S1S0=00 A&B, 01 A|B, 10 A^B, 11 ~A (per bit).
REQ-016 SHALL compute sum bit = x_i ^ ext_y ^ c and next carry = majority(x_i, ext_y, c), with c held in a carry register.
REQ-017 SHALL load the carry register at start with c0=1 for op 101 (subtract) and 110 (increment), else c0=0.
REQ-018 SHALL shift sum bits into result MSB-side so that result holds the full WIDTH-bit answer on the DONE cycle.
REQ-019 SHALL assert busy in SHIFT and DONE; done SHALL be high exactly in the DONE cycle, i.e. WIDTH+1 cycles after the start edge.
REQ-020 SHALL set cout = final carry register value, zero = (result==0), both updated in DONE and held with result until the next accepted start.
REQ-021 SHALL clear result, cout, zero, v on the edge that accepts a new start.

Reset
REQ-022 SHALL on rst_n=0, asynchronously and in any state including mid-SHIFT, force state=IDLE, counter=0, carry=0, result=0, cout=0, zero=0, v=0, busy=0, done=0, ext_*=0.
REQ-023 SHALL not generate done for an operation aborted by reset; first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-024 SHALL, with macro ALU_SERIAL_CTRL_OVF_FLAG_EN defined, set v in DONE to carry-into-MSB XOR carry-out-of-MSB (signed overflow) when M=1, 0 when M=0.
REQ-025 SHALL, without ALU_SERIAL_CTRL_OVF_FLAG_EN, keep port v present and tied to 0, with no extra registers.

Verification (WIDTH=8, extender model: M=1 00 y=b, 01 y=~b, 10 y=0, 11 y=1; M=0 y=0)
REQ-026 SHALL check op=100, a=0x3C, b=0x05 -> done 9 cycles after start, result=0x41, cout=0, zero=0.
REQ-027 SHALL check op=101, a=0x05, b=0x06 -> result=0xFF, cout=0, zero=0, v=0.
REQ-028 SHALL check op=110, a=0xFF -> result=0x00, cout=1, zero=1; op=111, a=0x80 -> result=0x7F, cout=1, v=1 with macro, v=0 without.
REQ-029 SHALL check op=001, a=0xA0, b=0x0F -> result=0xAF, cout=0; start re-pulsed at cycle 3 of SHIFT -> ignored, single done, result unchanged.
REQ-030 SHALL check rst_n pulsed low at SHIFT cycle 4 -> busy=0, result=0, no done; next start with op=100, a=0x01, b=0x01 -> result=0x02.
